// File: rtl/branch_pc_ctrl.sv
// branch_pc_ctrl
//   Branch/jump resolution and fetch-PC ownership for the RV32I core.
//   Decodes funct3 against the comparator results (BrEq/BrLt), decides
//   whether the EX-stage instruction redirects fetch, holds the fetch PC,
//   and raises a fixed-length flush after every redirect.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   stall         hazard stall, holds pc unless a redirect is taken
//   ex_valid      EX instruction is real (not a bubble)
//   is_branch     EX instruction is a conditional branch
//   is_jal        EX instruction is JAL
//   is_jalr       EX instruction is JALR
//   funct3        EX instruction funct3
//   BrEq, BrLt    comparator results
//   target        ALU-computed redirect target
//   BrUn          unsigned-compare select back to the comparator (comb)
//   taken         redirect decision for this cycle (comb)
//   pc            fetch PC (registered)
//   flush         squash IF/ID (registered, FLUSH_CYCLES long)
//   illegal_br    one-cycle pulse on a reserved branch funct3
//   misalign      one-cycle pulse when the redirect target has bit 1 set
//   br_cnt        resolved conditional branches (saturating)
//   taken_cnt     taken redirects, branches and jumps (saturating)
module branch_pc_ctrl #(
    parameter int                     DATA_LENGTH  = 32,
    parameter logic [DATA_LENGTH-1:0] RESET_PC     = '0,
    parameter int                     FLUSH_CYCLES = 2,
    parameter int                     CNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   ex_valid,
    input  logic                   is_branch,
    input  logic                   is_jal,
    input  logic                   is_jalr,
    input  logic [2:0]             funct3,
    input  logic                   BrEq,
    input  logic                   BrLt,
    input  logic [DATA_LENGTH-1:0] target,
    output logic                   BrUn,
    output logic                   taken,
    output logic [DATA_LENGTH-1:0] pc,
    output logic                   flush,
    output logic                   illegal_br,
    output logic                   misalign,
    output logic [CNT_WIDTH-1:0]   br_cnt,
    output logic [CNT_WIDTH-1:0]   taken_cnt
);

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    localparam logic [2:0] FCNT_INIT = 3'(FLUSH_CYCLES - 1);

    state_t                 state;
    state_t                 state_next;
    logic [2:0]             fcnt;
    logic [2:0]             fcnt_next;
    logic [DATA_LENGTH-1:0] pc_next;
    logic                   act;
    logic                   cond;
    logic                   legal;
    logic                   br_inc;
    logic                   ill_next;
    logic                   mis_next;

    // BLT/BGE and BLTU/BGEU share the same condition; funct3[1] picks signedness.
    assign BrUn = funct3[1];

    always_comb begin
        cond  = 1'b0;
        legal = 1'b1;
        case (funct3)
            3'b000:  cond = BrEq;
            3'b001:  cond = ~BrEq;
            3'b100:  cond = BrLt;
            3'b101:  cond = ~BrLt;
            3'b110:  cond = BrLt;
            3'b111:  cond = ~BrLt;
            default: legal = 1'b0;
        endcase
    end

    // EX holds a squashed instruction while flushing, so it never acts.
    assign act      = ex_valid & (state == RUN);
    assign taken    = act & (is_jal | is_jalr | (is_branch & cond));
    assign br_inc   = act & is_branch & legal;
    assign ill_next = act & is_branch & ~legal;
    assign mis_next = taken & target[1];

    always_comb begin
        state_next = state;
        fcnt_next  = fcnt;
        pc_next    = pc;

        // A redirect overrides stall; otherwise stall holds the PC in both states.
        if (taken) begin
            pc_next = {target[DATA_LENGTH-1:1], 1'b0};
        end else if (!stall) begin
            pc_next = pc + DATA_LENGTH'(4);
        end

        case (state)
            RUN: begin
                if (taken) begin
                    state_next = FLUSH;
                    fcnt_next  = FCNT_INIT;
                end
            end
            FLUSH: begin
                // fcnt runs regardless of stall so the flush length is fixed.
                if (fcnt == 3'd0) begin
                    state_next = RUN;
                end else begin
                    fcnt_next = fcnt - 3'd1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            fcnt  <= '0;
            pc    <= RESET_PC;
            flush <= 1'b0;
        end else begin
            state <= state_next;
            fcnt  <= fcnt_next;
            pc    <= pc_next;
            flush <= (state_next == FLUSH);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_br <= 1'b0;
            misalign   <= 1'b0;
            br_cnt     <= '0;
            taken_cnt  <= '0;
        end else begin
            illegal_br <= ill_next;
            misalign   <= mis_next;
            if (br_inc && (br_cnt != '1)) begin
                br_cnt <= br_cnt + CNT_WIDTH'(1);
            end
            if (taken && (taken_cnt != '1)) begin
                taken_cnt <= taken_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// tb_branch_pc_ctrl
//   Directed scenarios plus a randomized run against a cycle-level reference
//   model. A second instance with 4-bit counters shares all inputs so that
//   counter saturation is reachable in a short run.
module tb_branch_pc_ctrl;

    localparam int FC = 2;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        ex_valid;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic [2:0]  funct3;
    logic        BrEq;
    logic        BrLt;
    logic [31:0] target;

    logic        BrUn, taken, flush, illegal_br, misalign;
    logic [31:0] pc;
    logic [15:0] br_cnt, taken_cnt;

    logic        s_BrUn, s_taken, s_flush, s_illegal_br, s_misalign;
    logic [31:0] s_pc;
    logic [3:0]  s_br_cnt, s_taken_cnt;

    branch_pc_ctrl #(.DATA_LENGTH(32), .RESET_PC(32'h0), .FLUSH_CYCLES(FC), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .is_branch(is_branch),
        .is_jal(is_jal), .is_jalr(is_jalr), .funct3(funct3), .BrEq(BrEq), .BrLt(BrLt),
        .target(target), .BrUn(BrUn), .taken(taken), .pc(pc), .flush(flush),
        .illegal_br(illegal_br), .misalign(misalign), .br_cnt(br_cnt), .taken_cnt(taken_cnt)
    );

    branch_pc_ctrl #(.DATA_LENGTH(32), .RESET_PC(32'h0), .FLUSH_CYCLES(FC), .CNT_WIDTH(4)) u_sat (
        .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .is_branch(is_branch),
        .is_jal(is_jal), .is_jalr(is_jalr), .funct3(funct3), .BrEq(BrEq), .BrLt(BrLt),
        .target(target), .BrUn(s_BrUn), .taken(s_taken), .pc(s_pc), .flush(s_flush),
        .illegal_br(s_illegal_br), .misalign(s_misalign), .br_cnt(s_br_cnt), .taken_cnt(s_taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: m_fl is the number of flush cycles still to come.
    logic [31:0] m_pc;
    int          m_fl;
    int          m_br;
    int          m_tk;
    logic        m_ill;
    logic        m_mis;
    logic        e_taken, e_brun;
    logic        o_taken, o_brun;

    function automatic logic br_cond(input logic [2:0] f3, input logic eq, input logic lt);
        case (f3)
            3'b000:  return eq;
            3'b001:  return !eq;
            3'b100, 3'b110: return lt;
            3'b101, 3'b111: return !lt;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic br_legal(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // One clock: sample comb outputs mid-cycle, advance the model on the edge,
    // leave the caller 1 time unit after the edge to read registered outputs.
    task automatic step();
        @(negedge clk);
        e_brun  = funct3[1];
        e_taken = (m_fl == 0) && ex_valid &&
                  (is_jal || is_jalr || (is_branch && br_cond(funct3, BrEq, BrLt)));
        o_taken = taken;
        o_brun  = BrUn;
        @(posedge clk);
        if (rst) begin
            m_pc = 32'h0; m_fl = 0; m_br = 0; m_tk = 0; m_ill = 1'b0; m_mis = 1'b0;
        end else if (m_fl == 0) begin
            m_ill = ex_valid && is_branch && !br_legal(funct3);
            if (ex_valid && is_branch && br_legal(funct3)) m_br++;
            m_mis = e_taken && target[1];
            if (e_taken) begin
                m_tk++;
                m_pc = target & ~32'h1;
                m_fl = FC;
            end else if (!stall) begin
                m_pc = m_pc + 32'd4;
            end
        end else begin
            m_ill = 1'b0;
            m_mis = 1'b0;
            m_fl--;
            if (!stall) m_pc = m_pc + 32'd4;
        end
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; stall = 1'b0; ex_valid = 1'b0; is_branch = 1'b0; is_jal = 1'b0;
        is_jalr = 1'b0; funct3 = 3'b000; BrEq = 1'b0; BrLt = 1'b0; target = 32'h0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc actual=%h expected=%h", pc, 32'h0); end
        n_cmp++; if (flush !== 1'b0 || illegal_br !== 1'b0 || misalign !== 1'b0) begin
            n_err++; $display("FAIL reset_flags actual=%b%b%b expected=000", flush, illegal_br, misalign); end
        n_cmp++; if (br_cnt !== 16'h0 || taken_cnt !== 16'h0) begin
            n_err++; $display("FAIL reset_cnt actual=%h/%h expected=0/0", br_cnt, taken_cnt); end
        for (int i = 1; i <= 3; i++) begin
            step();
            n_cmp++; if (pc !== 32'(4 * i) || flush !== 1'b0) begin
                n_err++; $display("FAIL seq_pc actual=%h/%b expected=%h/0", pc, flush, 32'(4 * i)); end
        end
    endtask

    task automatic test_branch_eq();
        int guard;
        do_reset();
        guard = 0;
        while (m_pc != 32'h100 && guard < 100) begin step(); guard++; end
        n_cmp++; if (pc !== 32'h100) begin n_err++; $display("FAIL beq_reach_pc actual=%h expected=%h", pc, 32'h100); end
        ex_valid = 1'b1; is_branch = 1'b1; funct3 = 3'b000; BrEq = 1'b1; target = 32'h200;
        step();
        n_cmp++; if (o_taken !== 1'b1 || o_brun !== 1'b0) begin
            n_err++; $display("FAIL beq_comb actual=taken%b brun%b expected=taken1 brun0", o_taken, o_brun); end
        n_cmp++; if (pc !== 32'h200 || flush !== 1'b1) begin
            n_err++; $display("FAIL beq_redirect actual=%h/%b expected=200/1", pc, flush); end
        idle();
        step();
        n_cmp++; if (pc !== 32'h204 || flush !== 1'b1) begin
            n_err++; $display("FAIL beq_flush2 actual=%h/%b expected=204/1", pc, flush); end
        step();
        n_cmp++; if (pc !== 32'h208 || flush !== 1'b0) begin
            n_err++; $display("FAIL beq_flush_end actual=%h/%b expected=208/0", pc, flush); end
        n_cmp++; if (br_cnt !== 16'd1 || taken_cnt !== 16'd1) begin
            n_err++; $display("FAIL beq_cnt actual=%0d/%0d expected=1/1", br_cnt, taken_cnt); end
    endtask

    task automatic test_unsigned();
        do_reset();
        ex_valid = 1'b1; is_branch = 1'b1; funct3 = 3'b110; BrLt = 1'b0; target = 32'h400;
        step();
        n_cmp++; if (o_taken !== 1'b0 || o_brun !== 1'b1 || pc !== 32'h4) begin
            n_err++; $display("FAIL bltu actual=taken%b brun%b pc%h expected=taken0 brun1 pc4", o_taken, o_brun, pc); end
        funct3 = 3'b111;
        step();
        n_cmp++; if (o_taken !== 1'b1 || o_brun !== 1'b1 || pc !== 32'h400) begin
            n_err++; $display("FAIL bgeu actual=taken%b brun%b pc%h expected=taken1 brun1 pc400", o_taken, o_brun, pc); end
        n_cmp++; if (br_cnt !== 16'd2 || taken_cnt !== 16'd1) begin
            n_err++; $display("FAIL unsigned_cnt actual=%0d/%0d expected=2/1", br_cnt, taken_cnt); end
    endtask

    task automatic test_jalr_misalign_stall();
        do_reset();
        ex_valid = 1'b1; is_jalr = 1'b1; stall = 1'b1; target = 32'h0000_0207;
        step();
        n_cmp++; if (pc !== 32'h206 || misalign !== 1'b1 || flush !== 1'b1) begin
            n_err++; $display("FAIL jalr_redirect actual=%h mis%b fl%b expected=206 mis1 fl1", pc, misalign, flush); end
        idle(); stall = 1'b1;
        step();
        n_cmp++; if (pc !== 32'h206 || misalign !== 1'b0 || flush !== 1'b1) begin
            n_err++; $display("FAIL jalr_hold actual=%h mis%b fl%b expected=206 mis0 fl1", pc, misalign, flush); end
        step();
        n_cmp++; if (pc !== 32'h206 || flush !== 1'b0) begin
            n_err++; $display("FAIL jalr_flush_end actual=%h/%b expected=206/0", pc, flush); end
    endtask

    task automatic test_flush_and_illegal();
        do_reset();
        ex_valid = 1'b1; is_jal = 1'b1; target = 32'h80;
        step();
        is_jal = 1'b0; is_branch = 1'b1; funct3 = 3'b000; BrEq = 1'b1; target = 32'h300;
        step();
        n_cmp++; if (o_taken !== 1'b0 || pc !== 32'h84 || taken_cnt !== 16'd1 || br_cnt !== 16'd0) begin
            n_err++; $display("FAIL taken_in_flush actual=taken%b pc%h tc%0d bc%0d expected=taken0 pc84 tc1 bc0",
                              o_taken, pc, taken_cnt, br_cnt); end
        idle();
        step();
        ex_valid = 1'b1; is_branch = 1'b1; funct3 = 3'b010; BrEq = 1'b1; BrLt = 1'b1; target = 32'h500;
        step();
        n_cmp++; if (o_taken !== 1'b0 || illegal_br !== 1'b1 || pc !== 32'h8c || br_cnt !== 16'd0) begin
            n_err++; $display("FAIL illegal actual=taken%b ill%b pc%h bc%0d expected=taken0 ill1 pc8c bc0",
                              o_taken, illegal_br, pc, br_cnt); end
        idle();
        step();
        n_cmp++; if (illegal_br !== 1'b0) begin n_err++; $display("FAIL illegal_pulse actual=%b expected=0", illegal_br); end
    endtask

    task automatic test_reset_in_flush();
        do_reset();
        ex_valid = 1'b1; is_jal = 1'b1; target = 32'h40;
        step();
        idle(); rst = 1'b1;
        step();
        n_cmp++; if (pc !== 32'h0 || flush !== 1'b0 || taken_cnt !== 16'd0 || br_cnt !== 16'd0) begin
            n_err++; $display("FAIL rst_in_flush actual=pc%h fl%b tc%0d bc%0d expected=pc0 fl0 tc0 bc0",
                              pc, flush, taken_cnt, br_cnt); end
        rst = 1'b0;
        step();
        n_cmp++; if (pc !== 32'h4 || flush !== 1'b0) begin
            n_err++; $display("FAIL rst_in_flush_after actual=%h/%b expected=4/0", pc, flush); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            idle(); ex_valid = 1'b1; is_jal = 1'b1; target = 32'h1000 + 32'(i * 16);
            step();
            idle();
            step();
            step();
        end
        n_cmp++; if (taken_cnt !== 16'd20 || s_taken_cnt !== 4'hF) begin
            n_err++; $display("FAIL taken_sat actual=%0d/%0d expected=20/15", taken_cnt, s_taken_cnt); end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        ex_valid = 1'b1; is_jal = 1'b1; target = 32'hFFFF_FFFC;
        step();
        n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_setup actual=%h expected=fffffffc", pc); end
        idle(); stall = 1'b1;
        step();
        step();
        stall = 1'b0;
        step();
        n_cmp++; if (pc !== 32'h0 || flush !== 1'b0) begin
            n_err++; $display("FAIL pc_wrap actual=%h/%b expected=0/0", pc, flush); end
    endtask

    task automatic test_random();
        logic [15:0] e_bc, e_tc;
        logic [3:0]  e_sbc, e_stc;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 499) == 0);
            stall     = ($urandom_range(0, 3) == 0);
            ex_valid  = ($urandom_range(0, 3) != 0);
            is_branch = ($urandom_range(0, 1) == 0);
            is_jal    = ($urandom_range(0, 9) == 0);
            is_jalr   = ($urandom_range(0, 9) == 0);
            funct3    = 3'($urandom_range(0, 7));
            BrEq      = 1'($urandom_range(0, 1));
            BrLt      = 1'($urandom_range(0, 1));
            target    = $urandom;
            step();
            e_bc  = 16'(sat(m_br, 65535));
            e_tc  = 16'(sat(m_tk, 65535));
            e_sbc = 4'(sat(m_br, 15));
            e_stc = 4'(sat(m_tk, 15));
            n_cmp++;
            if (o_taken !== e_taken || o_brun !== e_brun || pc !== m_pc || flush !== (m_fl > 0) ||
                illegal_br !== m_ill || misalign !== m_mis || br_cnt !== e_bc || taken_cnt !== e_tc ||
                s_br_cnt !== e_sbc || s_taken_cnt !== e_stc) begin
                n_err++;
                $display("FAIL random[%0d] actual=tk%b un%b pc%h fl%b il%b ms%b bc%0d tc%0d sbc%0d stc%0d expected=tk%b un%b pc%h fl%b il%b ms%b bc%0d tc%0d sbc%0d stc%0d",
                         i, o_taken, o_brun, pc, flush, illegal_br, misalign, br_cnt, taken_cnt, s_br_cnt, s_taken_cnt,
                         e_taken, e_brun, m_pc, (m_fl > 0), m_ill, m_mis, e_bc, e_tc, e_sbc, e_stc);
            end
        end
        idle();
    endtask

    initial begin
        m_pc = 32'h0; m_fl = 0; m_br = 0; m_tk = 0; m_ill = 1'b0; m_mis = 1'b0;
        idle();
        test_reset();
        test_branch_eq();
        test_unsigned();
        test_jalr_misalign_stall();
        test_flush_and_illegal();
        test_reset_in_flush();
        test_saturation();
        test_pc_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_pc_ctrl.md
Name: branch_pc_ctrl

Overview:
- Next stage downstream of the branch comparator in the RV32I core. Consumes BrEq/BrLt, decodes funct3 of the EX-stage instruction and decides whether the branch is taken (branches, JAL, JALR).
- Owns the fetch PC register and generates the pipeline flush sequence after a redirect.
- Drives BrUn back to the comparator and keeps branch statistics counters.

Parameters:
- DATA_LENGTH, 32, width of PC and target datapath.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 2, number of cycles flush stays high after a redirect (legal range 1..7).
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard stall; holds PC when no redirect is pending.
- ex_valid  in  1  EX-stage instruction is valid (not a bubble).
- is_branch  in  1  EX instruction is a conditional branch.
- is_jal  in  1  EX instruction is JAL.
- is_jalr  in  1  EX instruction is JALR.
- funct3  in  3  EX instruction funct3.
- BrEq  in  1  comparator equal result.
- BrLt  in  1  comparator less-than result.
- target  in  DATA_LENGTH  ALU-computed branch/jump target.
- BrUn  out  1  unsigned-compare select to the comparator (combinational).
- taken  out  1  redirect decision for the current cycle (combinational).
- pc  out  DATA_LENGTH  fetch PC (registered).
- flush  out  1  squash IF/ID instructions (registered).
- illegal_br  out  1  one-cycle pulse for reserved funct3 on a branch (registered).
- misalign  out  1  one-cycle pulse when the redirect target has target[1]=1 (registered).
- br_cnt  out  CNT_WIDTH  count of resolved conditional branches.
- taken_cnt  out  CNT_WIDTH  count of taken redirects (branches plus jumps).

Behaviour:
- **BrUn**: BrUn = funct3[1], purely combinational; it is valid whenever funct3 is valid.
- **Branch condition by funct3**:
  - 000: taken = BrEq.
  - 001: taken = !BrEq.
  - 100: taken = BrLt.
  - 101: taken = !BrLt.
  - 110: taken = BrLt.
  - 111: taken = !BrLt.
  - 010, 011: not taken; illegal_br pulses the next cycle.
- **Taken**: taken = act & (is_jal | is_jalr | (is_branch & cond)), where act = ex_valid & (state == RUN).
- **Priority**: if several of is_branch/is_jal/is_jalr are set, jumps win; taken is 1.
- **Redirect target**: the next PC is target with bit 0 cleared, for all redirect types. misalign pulses for one cycle if target[1] = 1; the redirect still happens.
- **States**:
  - RUN: normal operation.
  - FLUSH: flush high, down-counter fcnt active.
- **Transitions**:
  - RUN & taken: pc <= redirect target, flush <= 1, fcnt <= FLUSH_CYCLES-1, go to FLUSH. The redirect overrides stall.
  - RUN & !taken & !stall: pc <= pc + 4.
  - RUN & !taken & stall: pc holds.
  - FLUSH: ex_valid is ignored (EX holds a squashed instruction); taken = 0; PC advances +4 when !stall and holds when stall.
  - FLUSH, fcnt: decrements every cycle, independent of stall. When fcnt == 0 at a clock edge, go to RUN and set flush <= 0.
- **Latency**: the redirect is visible on pc and flush one cycle after taken is asserted. flush stays high for exactly FLUSH_CYCLES cycles.
- **PC arithmetic**: pc + 4 wraps modulo 2^DATA_LENGTH (32'hFFFF_FFFC -> 32'h0000_0000), with no flag.
- **Counters**:
  - br_cnt increments when act & is_branch & funct3 is legal.
  - taken_cnt increments when taken.
  - Both saturate at all-ones and do not wrap.
- **Reset** (synchronous, wins over everything): pc = RESET_PC, state = RUN, flush = 0, fcnt = 0, illegal_br = 0, misalign = 0, br_cnt = 0, taken_cnt = 0. Asserting rst during FLUSH aborts the flush on the same edge.

Test Plan:
1. Reset, then run 3 cycles with no branches, stall=0 -> pc = 0, 4, 8, 12; flush = 0; counters = 0.
2. pc=0x100, ex_valid=1, is_branch=1, funct3=000, BrEq=1, target=0x200 -> taken=1 and BrUn=0 that cycle; next cycle pc=0x200, flush=1 for exactly 2 cycles, then pc=0x208 with flush=0; br_cnt=1, taken_cnt=1.
3. funct3=110, BrLt=0, then funct3=111, BrLt=0, with target=0x400 -> BrUn=1 both cycles; the first is not taken (pc+4), the second redirects to 0x400; br_cnt=2, taken_cnt=1.
4. is_jalr=1, target=0x0000_0207, stall=1 -> pc=0x206 next cycle, misalign pulses once, and the redirect occurs despite the stall. During FLUSH with stall=1, pc holds at 0x206 and flush still drops after 2 cycles.
5. Taken branch while in FLUSH (ex_valid=1, BrEq=1, funct3=000) -> taken=0, no redirect, taken_cnt unchanged. Separately, funct3=010 in RUN -> illegal_br pulses one cycle, no redirect, br_cnt unchanged.
6. rst asserted on the first FLUSH cycle -> next cycle pc=RESET_PC, flush=0, counters=0. Separately, preload taken_cnt to 16'hFFFF via repeated jumps -> it stays 16'hFFFF. Separately, pc=32'hFFFF_FFFC with no branch -> pc=0.
